// File: rtl/data_sync_tx.sv
// data_sync_tx: source-side launcher for a multi-cycle-path bus synchronizer.
// Captures a word on a valid/ready handshake, drives it onto unsync_bus with
// BUS_EN, and runs a four-phase request/acknowledge exchange. The acknowledge
// comes back through an NUM_STAGES flop synchronizer. A watchdog aborts a
// stalled phase and raises a sticky timeout_err.
//
// Handshake: a word moves from in_data into the block on a rising CLK edge
// where in_valid && in_ready are both high. in_valid may be held across cycles;
// the word is not consumed until that edge. in_ready does not depend on in_valid.
module data_sync_tx #(
    parameter int NUM_STAGES = 2,
    parameter int BUS_WIDTH  = 8,
    parameter int TIMEOUT    = 255,
    parameter int TO_W       = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [BUS_WIDTH-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [BUS_WIDTH-1:0] unsync_bus,
    output logic                 BUS_EN,
    input  logic                 ack_async,
    input  logic                 err_clr,
    output logic                 busy,
    output logic                 done_pulse,
    output logic                 timeout_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        RELEASE = 2'd2
    } state_t;

    // Watchdog is disabled entirely when TIMEOUT is zero.
    localparam bit              TO_EN   = (TIMEOUT != 0);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    state_t                 state_q, state_d;
    logic [NUM_STAGES-1:0]  ack_sync_q, ack_sync_d;
    logic [TO_W-1:0]        cnt_q, cnt_d;
    logic [BUS_WIDTH-1:0]   bus_q, bus_d;
    logic                   bus_en_q, bus_en_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic                   to_flag_q, to_flag_d;

    logic                   ack_s;
    logic                   to_hit;
    logic                   err_set;
    logic [TO_W-1:0]        cnt_inc;

    // Acknowledge synchronizer: ack_async enters stage 0, the top stage is ack_s.
    assign ack_sync_d = {ack_sync_q[NUM_STAGES-2:0], ack_async};
    assign ack_s      = ack_sync_q[NUM_STAGES-1];

    // Saturating increment so a long stall can never wrap back to a match.
    assign cnt_inc = (cnt_q == {TO_W{1'b1}}) ? cnt_q : cnt_q + TO_W'(1);
    assign to_hit  = TO_EN && (cnt_q == TO_LAST);

    // A stale acknowledge still high from an earlier exchange blocks acceptance.
    assign in_ready = !RST && (state_q == IDLE) && !ack_s;
    assign busy     = (state_q != IDLE);

    assign unsync_bus  = bus_q;
    assign BUS_EN      = bus_en_q;
    assign done_pulse  = done_q;
    assign timeout_err = err_q;

    // Next-state and registered-output logic for the four-phase exchange.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bus_d     = bus_q;
        bus_en_d  = bus_en_q;
        done_d    = 1'b0;
        to_flag_d = to_flag_q;
        err_set   = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    bus_d     = in_data;
                    bus_en_d  = 1'b1;
                    cnt_d     = '0;
                    to_flag_d = 1'b0;
                    state_d   = REQ;
                end
            end
            REQ: begin
                cnt_d = cnt_inc;
                if (ack_s) begin
                    bus_en_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = RELEASE;
                end else if (to_hit) begin
                    bus_en_d  = 1'b0;
                    err_set   = 1'b1;
                    to_flag_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = RELEASE;
                end
            end
            RELEASE: begin
                cnt_d = cnt_inc;
                if (!ack_s) begin
                    done_d  = !to_flag_q;
                    state_d = IDLE;
                end else if (to_hit) begin
                    err_set   = 1'b1;
                    to_flag_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: begin
                bus_en_d = 1'b0;
                state_d  = IDLE;
            end
        endcase

        // Sticky error: a new timeout outranks a simultaneous clear.
        if (err_set) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    // State, synchronizer and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            ack_sync_q <= '0;
            cnt_q      <= '0;
            bus_q      <= '0;
            bus_en_q   <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            to_flag_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ack_sync_q <= ack_sync_d;
            cnt_q      <= cnt_d;
            bus_q      <= bus_d;
            bus_en_q   <= bus_en_d;
            done_q     <= done_d;
            err_q      <= err_d;
            to_flag_q  <= to_flag_d;
        end
    end

endmodule

// File: tb/tb_data_sync_tx.sv
// tb_data_sync_tx: directed bench for data_sync_tx with NUM_STAGES=2 and a
// short TIMEOUT=8 watchdog. The destination is either an echo model that
// returns BUS_EN as ack after three cycles, or a bench-driven ack level.
module tb_data_sync_tx;

    localparam int BW = 8;

    logic          CLK;
    logic          RST;
    logic [BW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [BW-1:0] unsync_bus;
    logic          BUS_EN;
    logic          ack_async;
    logic          err_clr;
    logic          busy;
    logic          done_pulse;
    logic          timeout_err;

    logic          echo_en   = 1'b0;
    logic          ack_man   = 1'b0;
    logic [2:0]    echo_pipe = 3'b000;

    int checks = 0;
    int errors = 0;

    data_sync_tx #(
        .NUM_STAGES (2),
        .BUS_WIDTH  (BW),
        .TIMEOUT    (8),
        .TO_W       (8)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .unsync_bus  (unsync_bus),
        .BUS_EN      (BUS_EN),
        .ack_async   (ack_async),
        .err_clr     (err_clr),
        .busy        (busy),
        .done_pulse  (done_pulse),
        .timeout_err (timeout_err)
    );

    // Clock and destination model.
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) echo_pipe <= {echo_pipe[1:0], BUS_EN};
    assign ack_async = echo_en ? echo_pipe[2] : ack_man;

    // Global time limit.
    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "time limit");
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    int   first_acc, second_acc, n_rise, n_done, unstable, bound_hit;
    logic prev_en, acc;
    logic [BW-1:0] cur_word;
    logic [BW-1:0] words [2];

    initial begin
        RST = 1'b1; in_data = '0; in_valid = 1'b0; err_clr = 1'b0;

        // ---- 1: reset values ----
        step(); step();
        check_eq("rst_bus_en", 32'(BUS_EN), 32'(0));
        check_eq("rst_bus",    32'(unsync_bus), 32'(0));
        check_eq("rst_done",   32'(done_pulse), 32'(0));
        check_eq("rst_err",    32'(timeout_err), 32'(0));
        check_eq("rst_busy",   32'(busy), 32'(0));
        check_eq("rst_ready_in_rst", 32'(in_ready), 32'(0));
        RST = 1'b0; #1;
        check_eq("rst_ready_after", 32'(in_ready), 32'(1));

        // ---- 2: basic transfer, echo destination ----
        echo_en = 1'b1;
        in_data = 8'hA5; in_valid = 1'b1;
        step();
        in_valid = 1'b0; in_data = 8'h00;
        for (int k = 0; k <= 13; k++) begin
            check_eq($sformatf("basic_en_k%0d", k),    32'(BUS_EN),     32'(k <= 5));
            check_eq($sformatf("basic_bus_k%0d", k),   32'(unsync_bus), 32'(8'hA5));
            check_eq($sformatf("basic_done_k%0d", k),  32'(done_pulse), 32'(k == 12));
            check_eq($sformatf("basic_busy_k%0d", k),  32'(busy),       32'(k <= 11));
            check_eq($sformatf("basic_ready_k%0d", k), 32'(in_ready),   32'(k >= 12));
            step();
        end

        // ---- 3: back-to-back with in_valid held ----
        in_data = 8'h11; in_valid = 1'b1;
        first_acc = -1; second_acc = -1; n_rise = 0; n_done = 0; unstable = 0;
        prev_en = 1'b0; cur_word = '0; words[0] = '0; words[1] = '0;
        for (int c = 0; c < 40; c++) begin
            acc = in_valid && in_ready;
            step();
            if (acc) begin
                if (first_acc < 0) begin
                    first_acc = c; in_data = 8'h22;
                end else begin
                    second_acc = c; in_valid = 1'b0;
                end
            end
            if (BUS_EN && !prev_en) begin
                if (n_rise < 2) words[n_rise] = unsync_bus;
                n_rise++;
                cur_word = unsync_bus;
            end
            if (BUS_EN && unsync_bus != cur_word) unstable++;
            if (done_pulse) n_done++;
            prev_en = BUS_EN;
        end
        check_eq("b2b_first_acc", 32'(first_acc), 32'(0));
        check_eq("b2b_gap",       32'(second_acc - first_acc), 32'(13));
        check_eq("b2b_rises",     32'(n_rise), 32'(2));
        check_eq("b2b_dones",     32'(n_done), 32'(2));
        check_eq("b2b_unstable",  32'(unstable), 32'(0));
        check_eq("b2b_word0",     32'(words[0]), 32'(8'h11));
        check_eq("b2b_word1",     32'(words[1]), 32'(8'h22));
        check_eq("b2b_idle",      32'(busy), 32'(0));

        // ---- 4: REQ timeout, ack stuck low ----
        echo_en = 1'b0; ack_man = 1'b0;
        in_data = 8'h3C; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int k = 0; k <= 10; k++) begin
            check_eq($sformatf("reqto_en_k%0d", k),    32'(BUS_EN),      32'(k <= 7));
            check_eq($sformatf("reqto_err_k%0d", k),   32'(timeout_err), 32'(k >= 8));
            check_eq($sformatf("reqto_done_k%0d", k),  32'(done_pulse),  32'(0));
            check_eq($sformatf("reqto_busy_k%0d", k),  32'(busy),        32'(k <= 8));
            check_eq($sformatf("reqto_ready_k%0d", k), 32'(in_ready),    32'(k >= 9));
            check_eq($sformatf("reqto_bus_k%0d", k),   32'(unsync_bus),  32'(8'h3C));
            step();
        end
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check_eq("reqto_err_cleared", 32'(timeout_err), 32'(0));

        // ---- 5: RELEASE timeout, set beats clear ----
        in_data = 8'h96; in_valid = 1'b1;
        step();
        in_valid = 1'b0; ack_man = 1'b1;
        for (int k = 0; k <= 13; k++) begin
            if (k == 10) err_clr = 1'b1;
            if (k == 11) err_clr = 1'b0;
            check_eq($sformatf("relto_en_k%0d", k),    32'(BUS_EN),      32'(k <= 2));
            check_eq($sformatf("relto_err_k%0d", k),   32'(timeout_err), 32'(k >= 11));
            check_eq($sformatf("relto_busy_k%0d", k),  32'(busy),        32'(k <= 10));
            check_eq($sformatf("relto_ready_k%0d", k), 32'(in_ready),    32'(0));
            check_eq($sformatf("relto_done_k%0d", k),  32'(done_pulse),  32'(0));
            step();
        end

        // ---- 6: reset mid-REQ clears everything ----
        ack_man = 1'b0;
        step(); step(); step();
        check_eq("midrst_ready_pre", 32'(in_ready), 32'(1));
        in_data = 8'h5A; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step(); step();
        check_eq("midrst_en_pre", 32'(BUS_EN), 32'(1));
        RST = 1'b1;
        step();
        check_eq("midrst_en",    32'(BUS_EN), 32'(0));
        check_eq("midrst_busy",  32'(busy), 32'(0));
        check_eq("midrst_err",   32'(timeout_err), 32'(0));
        check_eq("midrst_bus",   32'(unsync_bus), 32'(0));
        check_eq("midrst_ready_in_rst", 32'(in_ready), 32'(0));
        RST = 1'b0; #1;
        check_eq("midrst_ready_after", 32'(in_ready), 32'(1));
        step();
        check_eq("midrst_en_after", 32'(BUS_EN), 32'(0));

        // ---- 7: stale ack out of reset ----
        ack_man = 1'b1;
        RST = 1'b1;
        step();
        RST = 1'b0;
        step(); step(); step();
        in_data = 8'hC3; in_valid = 1'b1; #1;
        check_eq("stale_ready", 32'(in_ready), 32'(0));
        for (int k = 0; k < 4; k++) begin
            step();
            check_eq($sformatf("stale_en_k%0d", k),   32'(BUS_EN), 32'(0));
            check_eq($sformatf("stale_busy_k%0d", k), 32'(busy), 32'(0));
        end
        ack_man = 1'b0;
        step();
        check_eq("stale_rel1_ready", 32'(in_ready), 32'(0));
        check_eq("stale_rel1_en",    32'(BUS_EN), 32'(0));
        step();
        check_eq("stale_rel2_ready", 32'(in_ready), 32'(1));
        check_eq("stale_rel2_en",    32'(BUS_EN), 32'(0));
        step();
        check_eq("stale_rel3_en",    32'(BUS_EN), 32'(1));
        check_eq("stale_rel3_bus",   32'(unsync_bus), 32'(8'hC3));
        in_valid = 1'b0; echo_en = 1'b1;
        n_done = 0; bound_hit = 1;
        for (int c = 0; c < 40; c++) begin
            step();
            if (done_pulse) n_done++;
            if (!busy) begin
                bound_hit = 0;
                break;
            end
        end
        check_eq("stale_finish_bound", 32'(bound_hit), 32'(0));
        check_eq("stale_done", 32'(n_done), 32'(1));
        check_eq("stale_bus_kept", 32'(unsync_bus), 32'(8'hC3));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
